// File: rtl/hazard_tracker.sv
// hazard_tracker
//   Hazard and forwarding unit for the 5-stage pipeline. It keeps the E/M/W
//   copies of {ra1, ra2, wa, res, tnew}. From those and the D-stage operand
//   info it produces the stall request and every forwarding mux select.
//
// Ports
//   clk, rst            clock (posedge); synchronous active-high reset
//   ra1D, ra2D, waD     D-stage source and destination registers
//   resD                result source: 0 NW, 1 ALU, 2 DM, 3 PC, 4 MD, 5-7 NW
//   tuse1D, tuse2D      cycles until rs/rt is consumed (3 = not used)
//   md_startD, md_accD  mult/div start code, HI/LO access by the D instr
//   stall               freeze PC and D, bubble into E
//   md_busy             mult/div unit busy
//   fwd1D, fwd2D        D select: 0 regfile, 1 E, 2 M, 3 W
//   fwd1E, fwd2E        E select: 0 pipe reg, 2 M, 3 W
//   fwd2M               M store-data select: 0 pipe reg, 1 W
//
// Build option: define HAZARD_MD_EN to track mult/div busy time. Without it,
//   md_startD and md_accD are ignored and md_busy is tied low.
module hazard_tracker #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ra1D,
  input  logic [4:0] ra2D,
  input  logic [4:0] waD,
  input  logic [2:0] resD,
  input  logic [1:0] tuse1D,
  input  logic [1:0] tuse2D,
  input  logic [1:0] md_startD,
  input  logic       md_accD,
  output logic       stall,
  output logic       md_busy,
  output logic [1:0] fwd1D,
  output logic [1:0] fwd2D,
  output logic [1:0] fwd1E,
  output logic [1:0] fwd2E,
  output logic       fwd2M
);

  typedef struct packed {
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [4:0] wa;
    logic [2:0] res;
    logic [1:0] tnew;
    logic [1:0] md_start;
  } entry_t;

  localparam entry_t BUBBLE = '0;

  entry_t r_e, r_m, r_w;
  entry_t w_d;
  logic   w_stall1, w_stall2, w_md_stall;

  function automatic logic writes(input entry_t e, input logic [4:0] r);
    return (e.wa == r) && (r != 5'd0) && (e.res != 3'd0) && (e.res <= 3'd4);
  endfunction

  function automatic logic [1:0] tnew_of(input logic [2:0] res);
    case (res)
      3'd1:    return 2'd1;
      3'd2:    return 2'd2;
      3'd4:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic entry_t age(input entry_t e);
    entry_t a;
    a = e;
    if (a.tnew != 2'd0) a.tnew = a.tnew - 2'd1;
    return a;
  endfunction

  function automatic logic src_stall(input entry_t e, input entry_t m,
                                     input logic [4:0] ra, input logic [1:0] tuse);
    return (ra != 5'd0) && (tuse != 2'd3) &&
           ((writes(e, ra) && (e.tnew > tuse)) || (writes(m, ra) && (m.tnew > tuse)));
  endfunction

  // Nearest writer decides; a writer whose value is not ready yet blocks
  // older stages instead of letting a stale value through.
  function automatic logic [1:0] fwd_d(input entry_t e, input entry_t m, input entry_t w,
                                       input logic [4:0] ra, input logic blocked);
    if (blocked)              return 2'd0;
    else if (writes(e, ra))   return (e.tnew == 2'd0) ? 2'd1 : 2'd0;
    else if (writes(m, ra))   return (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    else if (writes(w, ra))   return 2'd3;
    else                      return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_e(input entry_t m, input entry_t w, input logic [4:0] ra);
    if (writes(m, ra))        return (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    else if (writes(w, ra))   return 2'd3;
    else                      return 2'd0;
  endfunction

  always_comb begin
    w_d          = BUBBLE;
    w_d.ra1      = ra1D;
    w_d.ra2      = ra2D;
    w_d.wa       = waD;
    w_d.res      = resD;
    w_d.tnew     = tnew_of(resD);
`ifdef HAZARD_MD_EN
    w_d.md_start = (md_startD == 2'b11) ? 2'b00 : md_startD;
`endif
  end

`ifdef HAZARD_MD_EN
  logic [3:0] r_md_cnt;

  always_ff @(posedge clk) begin
    if (rst)                        r_md_cnt <= 4'd0;
    else if (r_e.md_start == 2'b01) r_md_cnt <= 4'(MULT_CYCLES);
    else if (r_e.md_start == 2'b10) r_md_cnt <= 4'(DIV_CYCLES);
    else if (r_md_cnt != 4'd0)      r_md_cnt <= r_md_cnt - 4'd1;
  end

  assign md_busy    = (r_md_cnt != 4'd0) || (r_e.md_start != 2'b00);
  assign w_md_stall = md_busy && (md_accD || (md_startD != 2'b00));
`else
  logic w_md_unused;
  assign w_md_unused = ^{md_startD, md_accD};
  assign md_busy     = 1'b0;
  assign w_md_stall  = 1'b0;
`endif

  assign w_stall1 = src_stall(r_e, r_m, ra1D, tuse1D);
  assign w_stall2 = src_stall(r_e, r_m, ra2D, tuse2D);
  assign stall    = w_stall1 || w_stall2 || w_md_stall;

  assign fwd1D = fwd_d(r_e, r_m, r_w, ra1D, w_stall1);
  assign fwd2D = fwd_d(r_e, r_m, r_w, ra2D, w_stall2);
  assign fwd1E = fwd_e(r_m, r_w, r_e.ra1);
  assign fwd2E = fwd_e(r_m, r_w, r_e.ra2);
  assign fwd2M = writes(r_w, r_m.ra2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e <= BUBBLE;
      r_m <= BUBBLE;
      r_w <= BUBBLE;
    end else begin
      r_w <= age(r_m);
      r_m <= age(r_e);
      r_e <= stall ? BUBBLE : w_d;
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
module tb_hazard_tracker;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam logic [2:0] NW = 3'd0, ALU = 3'd1, DM = 3'd2, PC = 3'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ra1D, ra2D, waD;
  logic [2:0] resD;
  logic [1:0] tuse1D, tuse2D, md_startD;
  logic       md_accD;
  logic       stall, md_busy, fwd2M;
  logic [1:0] fwd1D, fwd2D, fwd1E, fwd2E;

  int checks = 0;
  int failures = 0;

  hazard_tracker #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .ra1D(ra1D), .ra2D(ra2D), .waD(waD), .resD(resD),
    .tuse1D(tuse1D), .tuse2D(tuse2D),
    .md_startD(md_startD), .md_accD(md_accD),
    .stall(stall), .md_busy(md_busy),
    .fwd1D(fwd1D), .fwd2D(fwd2D), .fwd1E(fwd1E), .fwd2E(fwd2E),
    .fwd2M(fwd2M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a posedge; outputs are sampled 1 unit later.
  task automatic drv(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] wa,
                     input logic [2:0] res, input logic [1:0] tu1, input logic [1:0] tu2,
                     input logic [1:0] mds, input logic acc);
    ra1D = a1; ra2D = a2; waD = wa; resD = res;
    tuse1D = tu1; tuse2D = tu2; md_startD = mds; md_accD = acc;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nop;
    drv(0, 0, 0, NW, 3, 3, 0, 0);
  endtask

  task automatic flush;
    nop();
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1;
    drv(5, 6, 5, ALU, 0, 0, 2'b01, 1'b1);
    tick(); tick();
    rst = 1'b0;
    chk("rst_stall", stall, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_fwd1D", fwd1D, 0);
    chk("rst_fwd2D", fwd2D, 0);
    chk("rst_fwd1E", fwd1E, 0);
    chk("rst_fwd2E", fwd2E, 0);
    chk("rst_fwd2M", fwd2M, 0);
    flush();

    // ALU result consumed in E: no stall, later forwarded from M
    drv(0, 0, 8, ALU, 3, 3, 0, 0); tick();
    drv(8, 0, 0, NW, 1, 3, 0, 0);
    chk("alu_stall", stall, 0);
    chk("alu_fwd1D_notready", fwd1D, 0);
    tick();
    drv(8, 0, 0, NW, 0, 3, 0, 0);
    chk("alu_fwd1E_M", fwd1E, 2);
    chk("alu_fwd2E_none", fwd2E, 0);
    chk("alu_fwd1D_M", fwd1D, 2);
    chk("alu_D_from_M_stall", stall, 0);
    flush();

    // Load-use: exactly one bubble, then forward from W
    drv(0, 0, 9, DM, 3, 3, 0, 0); tick();
    drv(0, 9, 0, NW, 3, 1, 0, 0);
    chk("lu_stall_c1", stall, 1);
    tick();
    chk("lu_stall_c2", stall, 0);
    chk("lu_fwd2D_blocked", fwd2D, 0);
    tick();
    nop();
    chk("lu_fwd2E_W", fwd2E, 3);
    flush();

    // Load -> branch: two stall cycles, then forward from W
    drv(0, 0, 9, DM, 3, 3, 0, 0); tick();
    drv(9, 0, 0, NW, 0, 3, 0, 0);
    chk("lb_stall_c1", stall, 1);
    tick();
    chk("lb_stall_c2", stall, 1);
    tick();
    chk("lb_stall_c3", stall, 0);
    chk("lb_fwd1D_W", fwd1D, 3);
    flush();

    // $0 is never forwarded or stalled on
    drv(0, 0, 0, ALU, 3, 3, 0, 0); tick();
    drv(0, 0, 0, NW, 0, 3, 0, 0);
    chk("r0_stall", stall, 0);
    chk("r0_fwd1D", fwd1D, 0);
    // NW writer is ignored
    drv(0, 0, 5, NW, 3, 3, 0, 0); tick();
    drv(5, 0, 0, NW, 0, 3, 0, 0);
    chk("nw_stall", stall, 0);
    chk("nw_fwd1D", fwd1D, 0);
    // res codes 5-7 behave as NW
    drv(0, 0, 5, 3'd6, 3, 3, 0, 0); tick();
    drv(5, 0, 0, NW, 0, 3, 0, 0);
    chk("res6_stall", stall, 0);
    chk("res6_fwd1D", fwd1D, 0);
    // PC result is ready in E (tnew 0)
    drv(0, 0, 31, PC, 3, 3, 0, 0); tick();
    drv(31, 0, 0, NW, 0, 3, 0, 0);
    chk("pc_stall", stall, 0);
    chk("pc_fwd1D_E", fwd1D, 1);
    flush();

    // Nearer unready writer blocks the ready older one
    drv(0, 0, 4, ALU, 3, 3, 0, 0); tick();
    drv(0, 0, 4, ALU, 3, 3, 0, 0); tick();
    drv(4, 0, 0, NW, 0, 3, 0, 0);
    chk("prio_stall", stall, 1);
    chk("prio_fwd1D", fwd1D, 0);
    flush();

    // Store data forwarded W -> M
    drv(0, 0, 7, ALU, 3, 3, 0, 0); tick();
    drv(0, 7, 0, NW, 3, 2, 0, 0);
    chk("st_stall", stall, 0);
    chk("st_fwd2D", fwd2D, 0);
    tick();
    nop();
    chk("st_fwd2E_M", fwd2E, 2);
    tick();
    chk("st_fwd2M", fwd2M, 1);
    flush();

    // Reset mid-flight clears the pending load
    drv(0, 0, 9, DM, 3, 3, 0, 0); tick();
    drv(9, 0, 0, NW, 0, 3, 0, 0);
    chk("rmid_pre_stall", stall, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rmid_stall", stall, 0);
    chk("rmid_fwd1D", fwd1D, 0);
    flush();

`ifdef HAZARD_MD_EN
    begin
      int n;
      drv(0, 0, 0, NW, 3, 3, 2'b01, 0); tick();
      drv(0, 0, 0, NW, 3, 3, 0, 1);
      n = 0;
      for (int i = 0; i < 40 && stall; i++) begin
        n++;
        tick();
      end
      chk("md_mult_stall_cycles", n, MULT_CYCLES + 1);
      chk("md_busy_after", md_busy, 0);
      flush();
      drv(0, 0, 0, NW, 3, 3, 2'b10, 0); tick();
      drv(0, 0, 0, NW, 3, 3, 0, 1);
      chk("md_div_stall", stall, 1);
      repeat (3) tick();
      chk("md_div_busy", md_busy, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("md_rst_busy", md_busy, 0);
      chk("md_rst_stall", stall, 0);
      flush();
    end
`else
    drv(0, 0, 0, NW, 3, 3, 2'b01, 0); tick();
    drv(0, 0, 0, NW, 3, 3, 0, 1);
    chk("nomd_busy", md_busy, 0);
    chk("nomd_stall", stall, 0);
    flush();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
